// File: rtl/sim_ctrl_uart_if.sv
// CPU data-bus port of the simulation-control / console peripheral.
interface sim_ctrl_uart_if;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [31:0] dbus_wdata;
    logic        dbus_re;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_addr,
        output dbus_we,
        output dbus_wdata,
        output dbus_re,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_addr,
        input  dbus_we,
        input  dbus_wdata,
        input  dbus_re,
        output dbus_rdata
    );
endinterface

// File: rtl/sim_ctrl_uart.sv
// Simulation-control / console peripheral: putchar stores feed a TX FIFO serialised as 8N1 UART,
// a finish store raises the sticky fini_o once every queued character has left the wire.
module sim_ctrl_uart #(
    parameter logic [31:0] ADDR         = 32'h4000_8000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sim_ctrl_uart_if.slave        dbus,
    output logic                  txd_o,
    output logic                  fini_o,
    output logic                  busy_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            ovf_q, ovf_d;
    logic            fin_req_q, fin_req_d;
    logic            fini_q, fini_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            hit_we, hit_re, push, pop, empty, full, busy, baud_tick;
    logic [1:0]      cmd;
    logic [PW-1:0]   count;
    logic            unused_wdata;

    assign hit_we    = dbus.dbus_we && (dbus.dbus_addr == ADDR);
    assign hit_re    = dbus.dbus_re && (dbus.dbus_addr == ADDR);
    assign cmd       = dbus.dbus_wdata[17:16];
    assign count     = wptr_q - rptr_q;
    assign empty     = (wptr_q == rptr_q);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign busy      = !empty || (state_q != StIdle);
    assign baud_tick = (baud_q == BAUD_LAST);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign push      = hit_we && (cmd == 2'b01) && !full && !fin_req_q;
    assign pop       = (state_q == StIdle) && !empty;
    assign unused_wdata = ^{dbus.dbus_wdata[31:18], dbus.dbus_wdata[15:8]};

    // Bus decode, FIFO bookkeeping, status readback and finish tracking.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ovf_d     = ovf_q;
        fin_req_d = fin_req_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        // Drops after a finish request are intentional, not overflow.
        if (hit_we && (cmd == 2'b01) && full && !fin_req_q) begin
            ovf_d = 1'b1;
        end
        if (hit_we && (cmd == 2'b10)) begin
            fin_req_d = 1'b1;
        end
        fini_d  = fini_q || (fin_req_q && empty && (state_q == StIdle));
        // Status reflects the state before any store in the same cycle.
        rdata_d = hit_re ? {16'b0, fin_req_q, ovf_q, busy, full, empty, 3'b0, 8'(count)} : 32'b0;
    end

    // UART transmitter next state; txd is computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        unique case (state_q)
            StIdle: begin
                txd_d  = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    shift_d = mem_q[rptr_q[AW-1:0]];
                    state_d = StStart;
                    txd_d   = 1'b0;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StData: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StStop: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; a reset mid-frame abandons the frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ovf_q     <= 1'b0;
            fin_req_q <= 1'b0;
            fini_q    <= 1'b0;
            rdata_q   <= 32'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ovf_q     <= ovf_d;
            fin_req_q <= fin_req_d;
            fini_q    <= fini_d;
            rdata_q   <= rdata_d;
        end
    end

    // FIFO storage; stale contents are harmless because reset clears the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= dbus.dbus_wdata[7:0];
        end
    end

    assign dbus.dbus_rdata = rdata_q;
    assign txd_o           = txd_q;
    assign fini_o          = fini_q;
    assign busy_o          = busy;

endmodule

// File: tb/tb_sim_ctrl_uart.sv
// Self-checking bench for sim_ctrl_uart with a cycle-timed behavioural reference model.
module tb_sim_ctrl_uart;
    localparam logic [31:0] ADDR = 32'h4000_8000;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, fini, busy;

    always #5 clk = ~clk;

    sim_ctrl_uart_if bus ();

    sim_ctrl_uart #(
        .ADDR        (ADDR),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .dbus  (bus),
        .txd_o (txd),
        .fini_o(fini),
        .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte queue, sticky flags and the cycle at which the line is next idle.
    int         cyc     = 0;
    logic [7:0] mq[$];
    bit         m_ovf   = 0;
    bit         m_fin   = 0;
    bit         m_fini  = 0;
    int         idle_at = 0;
    int         fr_start = 0;
    bit         fr_valid = 0;
    logic [7:0] fr_byte  = 8'h00;
    logic [31:0] e_rdata = 32'h0;

    // {rdata, busy, fini, txd} as observed and as predicted after each clock.
    logic [34:0] got, want;

    // One bus cycle: drive inputs, advance the model, clock, then sample outputs.
    task automatic step(input bit r, input bit we, input logic [31:0] wd, input bit re,
                        input logic [31:0] addr);
        bit idle, hitw, hitr, full_pre, e_txd, e_busy;
        logic [31:0] st;
        int k;
        rst = r;
        bus.dbus_we = we;
        bus.dbus_wdata = wd;
        bus.dbus_re = re;
        bus.dbus_addr = addr;
        idle = (cyc >= idle_at);
        hitw = we && (addr == ADDR);
        hitr = re && (addr == ADDR);
        full_pre = (mq.size() == DEPTH);
        st = {16'b0, m_fin, m_ovf, (mq.size() != 0) || !idle, full_pre, mq.size() == 0,
              3'b0, 8'(mq.size())};
        if (r) begin
            mq.delete();
            m_ovf = 0; m_fin = 0; m_fini = 0;
            idle_at = cyc + 1; fr_valid = 0; e_rdata = 32'h0;
        end else begin
            e_rdata = hitr ? st : 32'h0;
            if (m_fin && mq.size() == 0 && idle) m_fini = 1;
            if (idle && mq.size() != 0) begin
                fr_byte = mq.pop_front();
                fr_start = cyc + 1;
                fr_valid = 1;
                idle_at = cyc + FRAME + 1;
            end
            if (hitw && wd[17:16] == 2'b01 && !m_fin) begin
                if (full_pre) m_ovf = 1;
                else mq.push_back(wd[7:0]);
            end
            if (hitw && wd[17:16] == 2'b10) m_fin = 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        e_busy = (mq.size() != 0) || (cyc < idle_at);
        e_txd = 1'b1;
        if (fr_valid && cyc >= fr_start && cyc < fr_start + FRAME) begin
            k = (cyc - fr_start) / CPB;
            e_txd = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fr_byte[k-1];
        end
        want = {e_rdata, e_busy, m_fini, e_txd};
        got  = {bus.dbus_rdata, busy, fini, txd};
    endtask

    task automatic idle_step();
        step(0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_reset();
        step(1, 0, 32'h0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle_step();
            if (got !== want) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        if ({txd, fini, busy} !== 3'b100) begin
            bad++; $display("FAIL reset_pins got=%b want=100", {txd, fini, busy});
        end
        total++;
        step(0, 0, 32'h0, 1, ADDR);
        if (bus.dbus_rdata !== 32'h0000_0800) begin
            bad++; $display("FAIL reset_status got=%h want=00000800", bus.dbus_rdata);
        end
        total++;
        idle_step();
        if (bus.dbus_rdata !== 32'h0) begin
            bad++; $display("FAIL rdata_nonhit got=%h want=0", bus.dbus_rdata);
        end
        total++;
    endtask

    task automatic test_single_char();
        step(0, 1, 32'h0001_0041, 0, ADDR);
        for (int i = 0; i < FRAME + 6; i++) begin
            idle_step();
            if (got !== want) begin bad++; $display("FAIL single_char cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
        total++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h0001_0030 + 32'(i), 0, ADDR);
            if (got !== want) begin bad++; $display("FAIL b2b_push cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        step(0, 0, 32'h0, 1, ADDR);
        if (bus.dbus_rdata[14] !== 1'b1) begin
            bad++; $display("FAIL b2b_ovf got=%b want=1", bus.dbus_rdata[14]);
        end
        total++;
        for (int i = 0; i < 5 * (FRAME + 1) + 4; i++) begin
            idle_step();
            if (got !== want) begin bad++; $display("FAIL b2b_drain cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        step(1, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_finish_drain();
        step(0, 1, 32'h0001_0048, 0, ADDR);
        step(0, 1, 32'h0001_0069, 0, ADDR);
        step(0, 1, 32'h0002_0000, 0, ADDR);
        for (int i = 0; i < 2 * (FRAME + 1) + 4; i++) begin
            if (i == 20) step(0, 1, 32'h0001_0058, 0, ADDR);
            else idle_step();
            if (got !== want) begin bad++; $display("FAIL fin_drain cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        step(0, 0, 32'h0, 1, ADDR);
        if (bus.dbus_rdata[15:14] !== 2'b10) begin
            bad++; $display("FAIL fin_flags got=%b want=10", bus.dbus_rdata[15:14]);
        end
        total++;
        step(1, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_finish_idle();
        idle_step();
        step(0, 1, 32'h0002_0000, 0, ADDR);
        if (fini !== 1'b0) begin bad++; $display("FAIL fin_early got=%b want=0", fini); end
        total++;
        idle_step();
        if (fini !== 1'b1) begin bad++; $display("FAIL fin_2cyc got=%b want=1", fini); end
        total++;
        step(0, 1, 32'h0002_0000, 0, ADDR);
        for (int i = 0; i < 4; i++) begin
            idle_step();
            if (got !== want) begin bad++; $display("FAIL fin_hold cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        step(1, 0, 32'h0, 0, 32'h0);
        if (fini !== 1'b0) begin bad++; $display("FAIL fin_clear got=%b want=0", fini); end
        total++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom);
        step(0, 1, {14'h0, 2'b01, 8'h0, b}, 0, ADDR);
        for (int i = 0; i < 18; i++) begin
            idle_step();
            if (got !== want) begin bad++; $display("FAIL mid_pre cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        step(1, 0, 32'h0, 0, 32'h0);
        if (txd !== 1'b1) begin bad++; $display("FAIL mid_txd got=%b want=1", txd); end
        total++;
        step(0, 0, 32'h0, 1, ADDR);
        if (bus.dbus_rdata !== 32'h0000_0800) begin
            bad++; $display("FAIL mid_status got=%h want=00000800", bus.dbus_rdata);
        end
        total++;
        step(0, 1, {14'h0, 2'b01, 8'h0, ~b}, 0, ADDR);
        for (int i = 0; i < FRAME + 4; i++) begin
            idle_step();
            if (got !== want) begin bad++; $display("FAIL mid_post cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
    endtask

    task automatic test_random();
        bit we, re;
        int sel;
        logic [1:0] c;
        logic [31:0] addr, wd;
        for (int i = 0; i < 900; i++) begin
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 7) == 0) ? (ADDR ^ (32'h1 << $urandom_range(0, 31))) : ADDR;
            sel = $urandom_range(0, 99);
            c = (sel == 0) ? 2'b10 : (sel < 8) ? 2'b00 : (sel < 15) ? 2'b11 : 2'b01;
            wd = $urandom;
            wd[17:16] = c;
            step(0, we, wd, re, addr);
            if (got !== want) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want); end
            total++;
        end
        step(1, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        bus.dbus_addr = 32'h0;
        bus.dbus_we = 1'b0;
        bus.dbus_wdata = 32'h0;
        bus.dbus_re = 1'b0;
        test_reset();
        test_single_char();
        test_back_to_back();
        test_finish_drain();
        test_finish_idle();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
